// File: rtl/fetch_instr_queue_if.sv
// Fetch->decode packet bundle seen by the instruction queue.
// Handshake: fetch may drive IN_valid in a cycle only if OUT_ready was 1 in the previous cycle.
// Decode consumes the presented lanes in every cycle where IN_decReady and |OUT_valid are both high.
interface fetch_instr_queue_if #(
  parameter int SLOTS = 4,
  parameter int DEC_W = 2,
  parameter int FID_W = 5
);
  logic                  IN_valid;
  logic [31:0]           IN_pc;
  logic [FID_W-1:0]      IN_fetchID;
  logic [SLOTS-1:0]      IN_slotMask;
  logic [SLOTS*32-1:0]   IN_instrs;
  logic [1:0]            IN_fault;
  logic                  OUT_ready;
  logic                  IN_flush;
  logic                  IN_decReady;
  logic [DEC_W-1:0]      OUT_valid;
  logic [DEC_W*32-1:0]   OUT_instr;
  logic [DEC_W*32-1:0]   OUT_pc;
  logic [FID_W-1:0]      OUT_fetchID;
  logic [1:0]            OUT_fault;

  modport slave (
    input  IN_valid, IN_pc, IN_fetchID, IN_slotMask, IN_instrs, IN_fault, IN_flush, IN_decReady,
    output OUT_ready, OUT_valid, OUT_instr, OUT_pc, OUT_fetchID, OUT_fault
  );

  modport master (
    output IN_valid, IN_pc, IN_fetchID, IN_slotMask, IN_instrs, IN_fault, IN_flush, IN_decReady,
    input  OUT_ready, OUT_valid, OUT_instr, OUT_pc, OUT_fetchID, OUT_fault
  );
endinterface

// File: rtl/fetch_instr_queue.sv
// Fetch packet queue feeding decode DEC_W instructions per cycle in program order.
// Optional FIQ_BYPASS_EN: an empty queue presents the incoming packet in the same cycle.
module fetch_instr_queue #(
  parameter int DEPTH = 4,
  parameter int SLOTS = 4,
  parameter int DEC_W = 2,
  parameter int FID_W = 5
) (
  input logic clk,
  input logic rst_n,
  fetch_instr_queue_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int NGRP = SLOTS / DEC_W;
  localparam int SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [31:0]         ent_pc     [DEPTH];
  logic [FID_W-1:0]    ent_fid    [DEPTH];
  logic [SLOTS-1:0]    ent_mask   [DEPTH];
  logic [SLOTS*32-1:0] ent_instrs [DEPTH];
  logic [1:0]          ent_fault  [DEPTH];

  logic [PW-1:0] head, tail, count, count_next;
  logic [SW-1:0] slot_ptr;
  logic          ready_q;
  logic          empty, full, in_keep, byp;

  assign count   = tail - head;
  assign empty   = (count == '0);
  assign full    = (count == PW'(DEPTH));
  // All-empty, fault-free packets carry nothing for decode and are never stored.
  assign in_keep = bus.IN_valid && !bus.IN_flush &&
                   ((|bus.IN_slotMask) || (bus.IN_fault != 2'd0));

`ifdef FIQ_BYPASS_EN
  assign byp = empty && in_keep;
`else
  assign byp = 1'b0;
`endif

  logic                sel_valid;
  logic [31:0]         sel_pc;
  logic [FID_W-1:0]    sel_fid;
  logic [SLOTS-1:0]    sel_mask;
  logic [SLOTS*32-1:0] sel_instrs;
  logic [1:0]          sel_fault;
  logic [SW-1:0]       sel_sp;

  assign sel_valid  = !empty || byp;
  assign sel_pc     = byp ? bus.IN_pc       : ent_pc[head[AW-1:0]];
  assign sel_fid    = byp ? bus.IN_fetchID  : ent_fid[head[AW-1:0]];
  assign sel_mask   = byp ? bus.IN_slotMask : ent_mask[head[AW-1:0]];
  assign sel_instrs = byp ? bus.IN_instrs   : ent_instrs[head[AW-1:0]];
  assign sel_fault  = byp ? bus.IN_fault    : ent_fault[head[AW-1:0]];
  assign sel_sp     = byp ? '0 : slot_ptr;

  // First group at or after slot_ptr holding a valid slot; rest flags any later group.
  logic [SW-1:0] cur_slot;
  logic          found, rest;
  always_comb begin
    cur_slot = '0;
    found    = 1'b0;
    rest     = 1'b0;
    for (int g = 0; g < NGRP; g++) begin
      if ((|sel_mask[g*DEC_W +: DEC_W]) && ((g * DEC_W) >= int'(sel_sp))) begin
        if (!found) begin
          found    = 1'b1;
          cur_slot = SW'(g * DEC_W);
        end else begin
          rest = 1'b1;
        end
      end
    end
  end

  logic [DEC_W-1:0]    out_valid;
  logic [DEC_W*32-1:0] out_instr, out_pc;
  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    if (sel_valid) begin
      if (sel_fault != 2'd0) begin
        out_valid[0]   = 1'b1;
        out_pc[31:0]   = sel_pc;
      end else if (found) begin
        for (int k = 0; k < DEC_W; k++) begin
          for (int s = 0; s < SLOTS; s++) begin
            if ((s == int'(cur_slot) + k) && sel_mask[s]) begin
              out_valid[k]         = 1'b1;
              out_instr[k*32 +: 32] = sel_instrs[s*32 +: 32];
              out_pc[k*32 +: 32]    = sel_pc + 32'(s * 4);
            end
          end
        end
      end
    end
  end

  logic fire, last, pop_head, enq_write;
  assign fire      = bus.IN_decReady && (|out_valid);
  assign last      = (sel_fault != 2'd0) || !rest;
  assign pop_head  = fire && last && !byp;
  // A bypassed packet that decode drains completely never needs an entry.
  assign enq_write = in_keep && !full && !(byp && fire && last);

  always_comb begin
    count_next = count;
    if (bus.IN_flush) count_next = '0;
    else              count_next = count + PW'(enq_write) - PW'(pop_head);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      slot_ptr <= '0;
      ready_q  <= 1'b1;
    end else begin
      assert (!(in_keep && full));
      ready_q <= (count_next <= PW'(DEPTH - 2));
      if (bus.IN_flush) begin
        head     <= tail;
        slot_ptr <= '0;
      end else begin
        if (pop_head)  head <= head + PW'(1);
        if (enq_write) tail <= tail + PW'(1);
        if (fire)      slot_ptr <= last ? '0 : (cur_slot + SW'(DEC_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq_write) begin
      ent_pc[tail[AW-1:0]]     <= bus.IN_pc;
      ent_fid[tail[AW-1:0]]    <= bus.IN_fetchID;
      ent_mask[tail[AW-1:0]]   <= bus.IN_slotMask;
      ent_instrs[tail[AW-1:0]] <= bus.IN_instrs;
      ent_fault[tail[AW-1:0]]  <= bus.IN_fault;
    end
  end

  assign bus.OUT_ready   = ready_q;
  assign bus.OUT_valid   = out_valid;
  assign bus.OUT_instr   = out_instr;
  assign bus.OUT_pc      = out_pc;
  assign bus.OUT_fetchID = sel_valid ? sel_fid : '0;
  assign bus.OUT_fault   = sel_valid ? sel_fault : 2'd0;
endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed checks of fetch_instr_queue: reset, packet walking, backpressure, flush, faults.
module tb_fetch_instr_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] exp_q[$];

  fetch_instr_queue_if #(.SLOTS(4), .DEC_W(2), .FID_W(5)) bus ();

  fetch_instr_queue #(.DEPTH(4), .SLOTS(4), .DEC_W(2), .FID_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] pc, input logic [4:0] fid, input logic [3:0] mask,
                      input logic [1:0] fault);
    bus.IN_valid    = 1'b1;
    bus.IN_pc       = pc;
    bus.IN_fetchID  = fid;
    bus.IN_slotMask = mask;
    bus.IN_fault    = fault;
    bus.IN_instrs   = {pc + 32'h33, pc + 32'h22, pc + 32'h11, pc};
  endtask

  task automatic idle();
    bus.IN_valid    = 1'b0;
    bus.IN_slotMask = 4'b0;
    bus.IN_fault    = 2'd0;
  endtask

  initial begin
    bus.IN_flush    = 1'b0;
    bus.IN_decReady = 1'b0;
    bus.IN_pc       = 32'h0;
    bus.IN_fetchID  = 5'd0;
    bus.IN_instrs   = '0;
    idle();
    #12;
    chk("rst_valid", 64'(bus.OUT_valid), 64'h0);
    chk("rst_ready", 64'(bus.OUT_ready), 64'h1);
    chk("rst_pc", bus.OUT_pc, 64'h0);
    chk("rst_fid_fault", {bus.OUT_fetchID, bus.OUT_fault}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Full packet, two lane pairs
    bus.IN_decReady = 1'b1;
    send(32'h1000, 5'd1, 4'b1111, 2'd0);
    tick();
    idle();
    chk("full_g0_valid", 64'(bus.OUT_valid), 64'h3);
    chk("full_g0_pc", bus.OUT_pc, {32'h1004, 32'h1000});
    chk("full_g0_instr", bus.OUT_instr, {32'h1011, 32'h1000});
    chk("full_g0_fid", 64'(bus.OUT_fetchID), 64'h1);
    tick();
    chk("full_g1_pc", bus.OUT_pc, {32'h100C, 32'h1008});
    chk("full_g1_instr", bus.OUT_instr, {32'h1033, 32'h1022});
    tick();
    chk("full_done_valid", 64'(bus.OUT_valid), 64'h0);
    chk("full_done_ready", 64'(bus.OUT_ready), 64'h1);

    // Three-slot packet ends with a single lane
    send(32'h2000, 5'd3, 4'b0111, 2'd0);
    tick();
    idle();
    chk("part_g0_pc", bus.OUT_pc, {32'h2004, 32'h2000});
    tick();
    chk("part_g1_valid", 64'(bus.OUT_valid), 64'h1);
    chk("part_g1_pc", bus.OUT_pc, {32'h0, 32'h2008});
    tick();
    chk("part_done_valid", 64'(bus.OUT_valid), 64'h0);

    // Backpressure: ready falls after the third entry, fourth in-flight packet still fits
    bus.IN_decReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'h3000 + 32'(i) * 32'h100, 5'(i), 4'b1111, 2'd0);
      exp_q.push_back({32'h0, 32'h3000 + 32'(i) * 32'h100});
      tick();
      chk($sformatf("bp_ready_%0d", i), 64'(bus.OUT_ready), (i < 2) ? 64'h1 : 64'h0);
    end
    idle();
    tick();
    chk("bp_hold_pc", bus.OUT_pc, {32'h3004, 32'h3000});
    bus.IN_decReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      chk($sformatf("drain_lane0_%0d", i), 64'(bus.OUT_pc[31:0]), e);
      chk($sformatf("drain_fid_%0d", i), 64'(bus.OUT_fetchID), 64'(i));
      tick();
      chk($sformatf("drain_lane0b_%0d", i), 64'(bus.OUT_pc[31:0]), e + 64'h8);
      tick();
    end
    chk("drain_empty", 64'(bus.OUT_valid), 64'h0);
    chk("drain_ready", 64'(bus.OUT_ready), 64'h1);

    // Flush with a same-cycle packet
    bus.IN_decReady = 1'b0;
    send(32'h4000, 5'd4, 4'b1111, 2'd0); tick();
    send(32'h5000, 5'd5, 4'b1111, 2'd0); tick();
    send(32'h6000, 5'd6, 4'b1111, 2'd0); tick();
    chk("fl_pre_ready", 64'(bus.OUT_ready), 64'h0);
    send(32'h7000, 5'd7, 4'b1111, 2'd0);
    bus.IN_flush = 1'b1;
    tick();
    bus.IN_flush = 1'b0;
    idle();
    chk("fl_valid", 64'(bus.OUT_valid), 64'h0);
    chk("fl_ready", 64'(bus.OUT_ready), 64'h1);
    bus.IN_decReady = 1'b1;
    tick();
    chk("fl_still_empty", 64'(bus.OUT_valid), 64'h0);
    send(32'h8000, 5'd8, 4'b1111, 2'd0);
    tick();
    idle();
    chk("fl_next_pc", bus.OUT_pc, {32'h8004, 32'h8000});
    tick();
    tick();
    chk("fl_next_done", 64'(bus.OUT_valid), 64'h0);

    // Fault packet is one lane-0 op; an empty fault-free packet is dropped
    send(32'h9000, 5'd7, 4'b0000, 2'd1);
    tick();
    idle();
    chk("flt_valid", 64'(bus.OUT_valid), 64'h1);
    chk("flt_code_fid", {bus.OUT_fetchID, bus.OUT_fault}, {57'h0, 5'd7, 2'd1});
    chk("flt_instr", bus.OUT_instr, 64'h0);
    chk("flt_pc", bus.OUT_pc, {32'h0, 32'h9000});
    tick();
    chk("flt_popped", 64'(bus.OUT_valid), 64'h0);
    send(32'hA000, 5'd2, 4'b0000, 2'd0);
    tick();
    idle();
    chk("drop_valid", 64'(bus.OUT_valid), 64'h0);

    // Asynchronous reset in the middle of traffic
    bus.IN_decReady = 1'b0;
    send(32'hB000, 5'd9, 4'b1111, 2'd0); tick();
    send(32'hC000, 5'd10, 4'b1111, 2'd0); tick();
    send(32'hD000, 5'd11, 4'b1111, 2'd0); tick();
    idle();
    chk("mid_ready_low", 64'(bus.OUT_ready), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.OUT_valid), 64'h0);
    chk("arst_ready", 64'(bus.OUT_ready), 64'h1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_after_valid", 64'(bus.OUT_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
